// File: rtl/qam_pkg.sv
// Shared constants for the QAM16 transmit chain.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package qam_pkg;

    // Default I/Q sample width and upsampling ratio of the transmit chain
    localparam int QAM_DW         = 3;
    localparam int QAM_UPS_FACTOR = 8;

    // Upsampler fill mode for the non-symbol phases
    localparam logic UPS_ZERO = 1'b0;
    localparam logic UPS_HOLD = 1'b1;

endpackage

// File: rtl/ups_phase_cnt.sv
// Modulo-FACTOR phase counter with run enable and synchronous clear.
// Latency: ph_o / ph_zero_o change one clock after en_i / rst_i.
// Backpressure: none; free-running while en_i=1, parked at 0 otherwise.
module ups_phase_cnt #(
    parameter  int FACTOR = 8,
    localparam int CW     = $clog2(FACTOR)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic [CW-1:0] ph_o,
    output logic          ph_zero_o
);

    localparam logic [CW-1:0] LAST = CW'(FACTOR - 1);

    logic [CW-1:0] ph_d, ph_q;
    logic          ph_zero_q;

    // Next phase: wrap at FACTOR-1, park at 0 whenever the block is idle
    always_comb begin
        ph_d = ph_q;
        if (!en_i) begin
            ph_d = '0;
        end else if (ph_q == LAST) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + 1'b1;
        end
    end

    // Phase register plus a flop-driven phase-0 flag, so in_ready is a single AND
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ph_q      <= '0;
            ph_zero_q <= 1'b1;
        end else begin
            ph_q      <= ph_d;
            ph_zero_q <= (ph_d == '0);
        end
    end

    assign ph_o      = ph_q;
    assign ph_zero_o = ph_zero_q;

endmodule

// File: rtl/upsample_nx.sv
// I/Q upsampler: one symbol per FACTOR clocks in, one sample per clock out (zero-insert or hold).
// Latency: 1 clock from the input/phase cycle to the registered output.
// Backpressure: in_ready only at phase 0 while enabled; output has no ready, a missing symbol flags underrun.
module upsample_nx
    import qam_pkg::*;
#(
    parameter int DW     = QAM_DW,
    parameter int FACTOR = QAM_UPS_FACTOR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_i,
    output logic signed [DW-1:0] out_q,
    output logic                 out_sym,
    output logic                 underrun,
    input  logic                 underrun_clr
);

    localparam int CW = $clog2(FACTOR);

    logic [CW-1:0] ph;
    logic          ph_zero;

    logic signed [DW-1:0] hold_i_d, hold_i_q;
    logic signed [DW-1:0] hold_q_d, hold_q_q;
    logic signed [DW-1:0] out_i_d, out_i_q;
    logic signed [DW-1:0] out_q_d, out_q_q;
    logic                 out_valid_d, out_valid_q;
    logic                 out_sym_d, out_sym_q;
    logic                 underrun_d, underrun_q;
    logic                 ur_set;

    ups_phase_cnt #(
        .FACTOR (FACTOR)
    ) u_phase (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .ph_o      (ph),
        .ph_zero_o (ph_zero)
    );

    assign in_ready = en & ph_zero;

    // Next output sample, hold value and underrun flag for the current phase
    always_comb begin
        out_valid_d = en;
        out_i_d     = '0;
        out_q_d     = '0;
        out_sym_d   = 1'b0;
        hold_i_d    = hold_i_q;
        hold_q_d    = hold_q_q;
        ur_set      = 1'b0;
        if (!en) begin
            // Idle drops any partial symbol so a restart never replays stale data
            hold_i_d = '0;
            hold_q_d = '0;
        end else if (ph == '0) begin
            if (in_valid) begin
                out_i_d   = in_i;
                out_q_d   = in_q;
                out_sym_d = 1'b1;
                hold_i_d  = in_i;
                hold_q_d  = in_q;
            end else begin
                // Missing symbol: emit zeros for the whole slot, even in hold mode
                hold_i_d = '0;
                hold_q_d = '0;
                ur_set   = 1'b1;
            end
        end else if (mode == UPS_HOLD) begin
            out_i_d = hold_i_q;
            out_q_d = hold_q_q;
        end
        // A new underrun outranks a simultaneous clear
        underrun_d = ur_set | (underrun_q & ~underrun_clr);
    end

    // Output, hold and sticky flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_i_q    <= '0;
            hold_q_q    <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_i_q    <= hold_i_d;
            hold_q_q    <= hold_q_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            underrun_q  <= underrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_sym   = out_sym_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_upsample_nx.sv
// Bench for upsample_nx: three instances (3b/8x, 3b/5x, 12b/16x) share one stimulus stream.
// Latency: model predicts each registered output one clock after the inputs it saw.
// Backpressure: each instance accepts only at its own phase 0; the model tracks that per instance.
module tb_upsample_nx;

    localparam int FAC [3] = '{8, 5, 16};
    localparam logic [11:0] MSK [3] = '{12'h007, 12'h007, 12'hFFF};

    logic        clk = 1'b0;
    logic        rst, en, mode, in_valid, underrun_clr;
    logic [11:0] in_i_w, in_q_w;

    always #5 clk = ~clk;

    logic [2:0]  a_oi, a_oq, b_oi, b_oq;
    logic [11:0] c_oi, c_oq;
    logic        d_ov [3];
    logic        d_sym[3];
    logic        d_ur [3];
    logic        d_rdy[3];
    logic [11:0] d_oi [3];
    logic [11:0] d_oq [3];

    upsample_nx #(.DW(3), .FACTOR(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(d_rdy[0]),
        .in_i(in_i_w[2:0]), .in_q(in_q_w[2:0]), .out_valid(d_ov[0]), .out_i(a_oi), .out_q(a_oq),
        .out_sym(d_sym[0]), .underrun(d_ur[0]), .underrun_clr(underrun_clr));

    upsample_nx #(.DW(3), .FACTOR(5)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(d_rdy[1]),
        .in_i(in_i_w[2:0]), .in_q(in_q_w[2:0]), .out_valid(d_ov[1]), .out_i(b_oi), .out_q(b_oq),
        .out_sym(d_sym[1]), .underrun(d_ur[1]), .underrun_clr(underrun_clr));

    upsample_nx #(.DW(12), .FACTOR(16)) dut_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(d_rdy[2]),
        .in_i(in_i_w), .in_q(in_q_w), .out_valid(d_ov[2]), .out_i(c_oi), .out_q(c_oq),
        .out_sym(d_sym[2]), .underrun(d_ur[2]), .underrun_clr(underrun_clr));

    assign d_oi[0] = {9'b0, a_oi};
    assign d_oq[0] = {9'b0, a_oq};
    assign d_oi[1] = {9'b0, b_oi};
    assign d_oq[1] = {9'b0, b_oq};
    assign d_oi[2] = c_oi;
    assign d_oq[2] = c_oq;

    int n_chk = 0;
    int n_err = 0;

    // Scoreboard queues of {i, q, sym}, one per instance
    logic [24:0] sq0[$];
    logic [24:0] sq1[$];
    logic [24:0] sq2[$];

    task automatic push_exp(input int k, input logic [24:0] e);
        case (k)
            0:       sq0.push_back(e);
            1:       sq1.push_back(e);
            default: sq2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int k, output logic [24:0] e, output bit ok);
        e  = '0;
        ok = 1'b0;
        case (k)
            0:       if (sq0.size() > 0) begin e = sq0.pop_front(); ok = 1'b1; end
            1:       if (sq1.size() > 0) begin e = sq1.pop_front(); ok = 1'b1; end
            default: if (sq2.size() > 0) begin e = sq2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t: got %0h want %0h", name, k, $time, act, exp);
        end
    endtask

    // Reference model: cycles since enable modulo FACTOR give the slot position;
    // slot start takes the offered symbol (or zeros + underrun), later positions zero or repeat it.
    int          run_cnt[3];
    logic [11:0] m_hi[3];
    logic [11:0] m_hq[3];
    bit          m_ur[3];
    bit          m_vld[3];
    logic [11:0] m_si, m_sq;
    bit          m_sy, m_set;

    initial begin
        for (int k = 0; k < 3; k++) begin
            run_cnt[k] = 0; m_hi[k] = '0; m_hq[k] = '0; m_ur[k] = 1'b0; m_vld[k] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                run_cnt[k] = 0; m_hi[k] = '0; m_hq[k] = '0; m_ur[k] = 1'b0; m_vld[k] = 1'b0;
            end else begin
                m_set    = 1'b0;
                m_vld[k] = en;
                if (en) begin
                    m_si = '0; m_sq = '0; m_sy = 1'b0;
                    if (run_cnt[k] % FAC[k] == 0) begin
                        if (in_valid) begin
                            m_si = in_i_w & MSK[k];
                            m_sq = in_q_w & MSK[k];
                            m_sy = 1'b1;
                        end else begin
                            m_set = 1'b1;
                        end
                        m_hi[k] = m_si;
                        m_hq[k] = m_sq;
                    end else if (mode) begin
                        m_si = m_hi[k];
                        m_sq = m_hq[k];
                    end
                    push_exp(k, {m_si, m_sq, m_sy});
                    run_cnt[k] = run_cnt[k] + 1;
                end else begin
                    run_cnt[k] = 0; m_hi[k] = '0; m_hq[k] = '0;
                end
                m_ur[k] = m_set | (m_ur[k] & ~underrun_clr);
            end
        end
    end

    // Monitor: just after each edge, compare every instance against the model / scoreboard
    logic [24:0] mon_e;
    bit          mon_ok;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("out_valid", k, 32'(d_ov[k]), 32'(m_vld[k]));
            chk("underrun", k, 32'(d_ur[k]), 32'(m_ur[k]));
            chk("in_ready", k, 32'(d_rdy[k]), 32'(en && (run_cnt[k] % FAC[k] == 0)));
            if (d_ov[k]) begin
                pop_exp(k, mon_e, mon_ok);
                if (!mon_ok) begin
                    n_chk++; n_err++;
                    $display("FAIL sb_empty inst%0d t=%0t: got out_valid=1 want no sample", k, $time);
                end else begin
                    chk("out_i", k, 32'(d_oi[k]), 32'(mon_e[24:13]));
                    chk("out_q", k, 32'(d_oq[k]), 32'(mon_e[12:1]));
                    chk("out_sym", k, 32'(d_sym[k]), 32'(mon_e[0]));
                end
            end else begin
                chk("idle_out", k, {7'b0, d_sym[k], d_oi[k], d_oq[k]}, 32'd0);
            end
        end
    end

    // Wait (at negedge) until the 8x instance sits at phase p, with a bound
    task automatic wait_ph(input int p);
        int n = 0;
        while ((run_cnt[0] % 8) != p && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            n_chk++; n_err++;
            $display("FAIL wait_ph: got no phase %0d within 64 cycles want reached", p);
        end
    endtask

    int sym_i[3] = '{3, -2, 1};
    int sym_q[3] = '{-1, 0, 2};

    task automatic run_syms(input logic m);
        mode = m; en = 1'b1; in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_i_w = 12'(sym_i[j]);
            in_q_w = 12'(sym_q[j]);
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0;
        in_i_w = '0; in_q_w = '0; underrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-insert, then sample-hold, on the fixed symbol list
        run_syms(1'b0);
        run_syms(1'b1);

        // Missing symbol at a slot start, then sticky flag, clear, and clear colliding with a new set
        mode = 1'b0;
        wait_ph(0);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        in_valid = 1'b1;
        repeat (12) @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        wait_ph(0);
        in_valid = 1'b0; underrun_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; underrun_clr = 1'b0;
        repeat (10) @(negedge clk);

        // Enable dropped mid-symbol and restored four cycles later
        wait_ph(3);
        en = 1'b0;
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (16) @(negedge clk);

        // Mode switch mid-symbol, then reset mid-symbol
        mode = 1'b0;
        wait_ph(0);
        in_i_w = 12'(3); in_q_w = 12'(-1);
        @(negedge clk);
        wait_ph(4);
        mode = 1'b1;
        wait_ph(6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Random traffic: 80% valid, occasional en drops, mode flips and clears
        for (int c = 0; c < 3000; c++) begin
            in_valid     = ($urandom_range(99) < 80);
            in_i_w       = 12'($urandom);
            in_q_w       = 12'($urandom);
            underrun_clr = ($urandom_range(99) < 5);
            if ($urandom_range(99) < 2) mode = ~mode;
            en           = ($urandom_range(99) < 97);
            @(negedge clk);
        end
        en = 1'b0; in_valid = 1'b0; underrun_clr = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
